// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit hex display scanner.
// Holds digit count, digit-index width and the default prescaler divisor.
package seg_scan_pkg;

  localparam int NDIG        = 4;
  localparam int IDX_W       = 2;
  localparam int DATA_W      = 4 * NDIG;
  localparam int DIV_DEFAULT = 50000;

  // Blanked-digit mask: digit i>0 is dark when it and every more-significant nibble are zero.
  function automatic logic [NDIG-1:0] lz_mask(input logic [DATA_W-1:0] disp,
                                              input logic              blank);
    logic [NDIG-1:0] m;
    m    = '0;
    m[1] = blank && (disp[15:4]  == 12'h000);
    m[2] = blank && (disp[15:8]  == 8'h00);
    m[3] = blank && (disp[15:12] == 4'h0);
    return m;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [DATA_W-1:0] disp,
                                           input logic [IDX_W-1:0]  idx);
    logic [3:0] n;
    n = 4'h0;
    case (idx)
      2'd0:    n = disp[3:0];
      2'd1:    n = disp[7:4];
      2'd2:    n = disp[11:8];
      default: n = disp[15:12];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled and flags the last cycle of each slot.
// The count freezes (and TICK stays low) while EN is low.
module scan_tick #(
  parameter int DIV = 50000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic EN,
  output logic TICK
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign TICK   = EN && w_last;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (EN) begin
      if (w_last) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode hex display with frame-synchronous
// value updates and optional leading-zero blanking. Segment decoding lives outside.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic        LD,
  input  logic [15:0] D,
  input  logic        BLANK,
  output logic [3:0]  N,
  output logic [3:0]  SEL_n,
  output logic        FRAME
);

  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_pend;
  logic              r_pflag;
  logic              r_frame;

  logic              w_tick;
  logic              w_wrap;
  logic [NDIG-1:0]   w_blanked;
  logic [NDIG-1:0]   w_onehot;
  logic              w_lit;

  scan_tick #(
    .DIV (DIV)
  ) u_tick (
    .CLK  (CLK),
    .RSTn (RSTn),
    .EN   (EN),
    .TICK (w_tick)
  );

  assign w_wrap = w_tick && (r_idx == IDX_W'(NDIG - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Displayed value changes only at the frame wrap so a frame never mixes old and new digits.
  // A load coinciding with the wrap bypasses the pending stage entirely.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_disp  <= '0;
      r_pend  <= '0;
      r_pflag <= 1'b0;
    end else if (w_wrap) begin
      if (LD) begin
        r_disp <= D;
      end else if (r_pflag) begin
        r_disp <= r_pend;
      end
      r_pflag <= 1'b0;
    end else if (LD) begin
      r_pend  <= D;
      r_pflag <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) r_frame <= 1'b0;
    else       r_frame <= w_wrap;
  end

  assign w_blanked = lz_mask(r_disp, BLANK);
  assign w_onehot  = NDIG'(1) << r_idx;
  assign w_lit     = EN && !w_blanked[r_idx];

  assign N     = nibble_at(r_disp, r_idx);
  assign SEL_n = w_lit ? ~w_onehot : 4'b1111;
  // Gated so a disable right after a wrap cannot leave a stray FRAME pulse visible.
  assign FRAME = r_frame && EN;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at DIV=4 (16 cycles per frame); checks scan order,
// frame-synchronous loads, blanking, enable freeze and mid-frame reset.
module tb_seg_scan;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        EN;
  logic        LD;
  logic [15:0] D;
  logic        BLANK;
  logic [3:0]  N;
  logic [3:0]  SEL_n;
  logic        FRAME;

  int checks = 0;
  int errors = 0;

  seg_scan #(.DIV(4)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .EN    (EN),
    .LD    (LD),
    .D     (D),
    .BLANK (BLANK),
    .N     (N),
    .SEL_n (SEL_n),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a wrap edge; checks the first cycle of each slot and the FRAME pulse.
  task automatic frame_chk(input string tag, input logic [15:0] ns, input logic [15:0] sels);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_N"}, {12'h0, N}, {12'h0, ns[4*k +: 4]});
      chk({tag, "_SEL"}, {12'h0, SEL_n}, {12'h0, sels[4*k +: 4]});
      if (k == 0) begin
        chk({tag, "_FRAME1"}, {15'h0, FRAME}, 16'd1);
        step(1);
        chk({tag, "_FRAME0"}, {15'h0, FRAME}, 16'd0);
        step(3);
      end else begin
        step(4);
      end
    end
  endtask

  initial begin
    RSTn = 1'b0; EN = 1'b1; LD = 1'b0; D = 16'h0000; BLANK = 1'b0;
    step(2);
    chk("rst_N", {12'h0, N}, 16'h0);
    chk("rst_SEL_en1", {12'h0, SEL_n}, 16'hE);
    chk("rst_FRAME", {15'h0, FRAME}, 16'd0);
    EN = 1'b0; #1;
    chk("rst_SEL_en0", {12'h0, SEL_n}, 16'hF);
    EN = 1'b1;
    // Load during reset must be ignored.
    LD = 1'b1; D = 16'hFFFF;
    step(1);
    LD = 1'b0;
    chk("rst_ld_ignored", {12'h0, N}, 16'h0);

    // Release: the edge after this point is cycle 1; first wrap at cycle 16.
    RSTn = 1'b1;
    step(1);
    LD = 1'b1; D = 16'h1234;
    step(1);
    LD = 1'b0;
    step(13);
    chk("pre_wrap_N", {12'h0, N}, 16'h0);
    chk("pre_wrap_SEL", {12'h0, SEL_n}, 16'h7);
    chk("pre_wrap_FRAME", {15'h0, FRAME}, 16'd0);
    step(1);
    frame_chk("f1234", 16'h1234, 16'h7BDE);

    // Leading-zero blanking with 0050.
    LD = 1'b1; D = 16'h0050; BLANK = 1'b1;
    step(1);
    LD = 1'b0;
    step(15);
    frame_chk("blank0050", 16'h0050, 16'hFFDE);
    BLANK = 1'b0;
    frame_chk("noblank0050", 16'h0050, 16'h7BDE);

    // All-zero value: only digit 0 lit.
    LD = 1'b1; D = 16'h0000; BLANK = 1'b1;
    step(1);
    LD = 1'b0;
    step(15);
    frame_chk("blank0000", 16'h0000, 16'hFFFE);

    // Two loads in one frame: the later one wins.
    BLANK = 1'b0;
    LD = 1'b1; D = 16'hAAAA;
    step(1);
    D = 16'hBBBB;
    step(1);
    LD = 1'b0;
    chk("no_tear_N", {12'h0, N}, 16'h0);
    step(14);
    frame_chk("fBBBB", 16'hBBBB, 16'hBBBB ^ 16'hBBBB ^ 16'h7BDE);

    // Pending 1111, then a load exactly on the wrap edge overrides it and leaves no pending.
    step(6);
    LD = 1'b1; D = 16'h1111;
    step(1);
    LD = 1'b0;
    step(8);
    LD = 1'b1; D = 16'hC0DE;
    step(1);
    LD = 1'b0;
    frame_chk("fC0DE_a", 16'hC0DE, 16'h7BDE);
    frame_chk("fC0DE_b", 16'hC0DE, 16'h7BDE);

    // Freeze mid-slot 0 for 10 cycles; pending still loads.
    step(1);
    EN = 1'b0; #1;
    chk("frz_SEL", {12'h0, SEL_n}, 16'hF);
    LD = 1'b1; D = 16'h9876;
    step(1);
    LD = 1'b0;
    step(9);
    chk("frz_SEL_end", {12'h0, SEL_n}, 16'hF);
    chk("frz_FRAME", {15'h0, FRAME}, 16'd0);
    chk("frz_N", {12'h0, N}, 16'hE);
    EN = 1'b1; #1;
    chk("resume_SEL", {12'h0, SEL_n}, 16'hE);
    step(2);
    chk("resume_slot0_SEL", {12'h0, SEL_n}, 16'hE);
    step(1);
    chk("resume_slot1_SEL", {12'h0, SEL_n}, 16'hD);
    chk("resume_slot1_N", {12'h0, N}, 16'hD);
    step(11);
    chk("resume_pre_wrap_N", {12'h0, N}, 16'hC);
    chk("resume_pre_wrap_FRAME", {15'h0, FRAME}, 16'd0);
    step(1);
    chk("en0_load_N", {12'h0, N}, 16'h6);
    chk("en0_load_FRAME", {15'h0, FRAME}, 16'd1);

    // Mid-frame reset discards pending and restarts the scan.
    step(1);
    LD = 1'b1; D = 16'h5555;
    step(1);
    LD = 1'b0; RSTn = 1'b0;
    step(1);
    chk("midrst_N", {12'h0, N}, 16'h0);
    chk("midrst_SEL", {12'h0, SEL_n}, 16'hE);
    chk("midrst_FRAME", {15'h0, FRAME}, 16'd0);
    RSTn = 1'b1;
    step(15);
    chk("midrst_pre_wrap_SEL", {12'h0, SEL_n}, 16'h7);
    chk("midrst_pre_wrap_FRAME", {15'h0, FRAME}, 16'd0);
    step(1);
    frame_chk("midrst_f0", 16'h0000, 16'h7BDE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RSTn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port EN  input  1  scan enable; 0 freezes scanning and blanks the display.
REQ-005 The block SHALL have port LD  input  1  load strobe for D, sampled on each CLK edge.
REQ-006 The block SHALL have port D  input  16  four hex digits, digit 0 = D[3:0] (rightmost).
REQ-007 The block SHALL have port BLANK  input  1  leading-zero blanking enable.
REQ-008 The block SHALL have port N  output  4  nibble of the current digit, fed to the hex-to-7-segment decoder.
REQ-009 The block SHALL have port SEL_n  output  4  active-low one-hot digit select; SEL_n[i] = 0 lights digit i.
REQ-010 The block SHALL have port FRAME  output  1  one-cycle pulse at each 3->0 digit wrap.

Function
REQ-011 Prescaler count SHALL run 0..DIV-1 while EN=1, wrap to 0, and assert internal tick on the cycle its count equals DIV-1.
REQ-012 Digit index (2 bits) SHALL advance by 1 on the edge where tick=1, wrapping 3->0; it SHALL hold otherwise.
REQ-013 LD=1 SHALL capture D into a pending register and set a pending flag; a later LD before the flag clears SHALL overwrite the pending value.
REQ-014 The displayed value SHALL take the pending value only on the 3->0 wrap edge, clearing the flag; there SHALL be no mid-frame tearing.
REQ-015 LD=1 on the wrap edge itself SHALL load D directly into the displayed value and leave the flag clear.
REQ-016 N SHALL equal displayed[4*idx+3 : 4*idx], a function of registered state only.
REQ-017 SEL_n SHALL equal ~(1<<idx) when EN=1 and the digit is not blanked; otherwise it SHALL be 4'b1111.
REQ-018 With BLANK=1, digit i>0 SHALL be blanked when all displayed nibbles i..3 are zero; digit 0 SHALL never be blanked.
REQ-019 With EN=0, the prescaler count, idx, and the displayed value SHALL hold, SEL_n SHALL be 1111, and FRAME SHALL be 0; LD SHALL still update the pending register.
REQ-020 FRAME SHALL be registered and high for exactly the cycle after the 3->0 wrap edge.
REQ-021 On the EN 0->1 transition, scanning SHALL resume from the held count and idx with no extra tick.

Reset
REQ-022 RSTn=0 at a CLK edge SHALL clear the prescaler count, idx, displayed, pending, the flag, and FRAME, regardless of EN or LD.
REQ-023 During and after reset, N SHALL read 0 and SEL_n SHALL read 1110 if EN=1 or 1111 if EN=0.
REQ-024 Reset mid-frame SHALL discard any pending value; the first wrap after reset SHALL occur 4*DIV cycles after RSTn deasserts with EN=1.

Structure
REQ-025 A shared package SHALL hold NDIG=4, the idx width 2, and the default DIV.
REQ-026 The prescaler SHALL be a sub-module, scan_tick (parameter DIV; ports CLK, RSTn, EN, TICK).
REQ-027 seg_scan SHALL NOT contain segment decoding; N connects externally to the existing hex decoder.

Verification (DIV=4)
REQ-028 Reset, EN=1, LD pulse with D=16'h1234 at cycle 2 -> displayed stays 0 until the first wrap at cycle 16, FRAME pulses at cycle 17, then N cycles 4,3,2,1 with SEL_n 1110,1101,1011,0111, 4 cycles each.
REQ-029 D=16'h0050, BLANK=1 -> digits 0 and 1 light (N=0, then N=5), slots 2 and 3 show SEL_n=1111; with BLANK=0 all four slots light.
REQ-030 D=16'h0000, BLANK=1 -> only digit 0 lights, N=0.
REQ-031 LD with D=16'hAAAA, then LD with D=16'hBBBB in the same frame -> next frame shows B in every slot and never shows A.
REQ-032 LD exactly on the wrap edge with D=16'hC0DE -> the frame starting at that edge shows E,D,0,C.
REQ-033 EN=0 for 10 cycles mid-slot -> SEL_n=1111, FRAME=0, idx unchanged; after EN=1 the slot completes its remaining cycles; RSTn=0 mid-frame -> idx=0 and the pending value is lost.
